// File: rtl/lock_entry_ctrl.sv
// Entry sequencer for the 5-digit combination lock: frames attempts, forwards digits,
// handles door timing, failure counting and lockout. Optional macro: LOCK_ALARM_ACK_EN.
module lock_entry_ctrl #(
  parameter int CODE_LEN       = 5,
  parameter int MAX_FAILS      = 3,
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int ENTRY_TIMEOUT  = 32,
  localparam int FW = $clog2(MAX_FAILS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_zero,
  input  logic          key_one,
  input  logic          key_clear,
  input  logic          lock_unlocked,
`ifdef LOCK_ALARM_ACK_EN
  input  logic          alarm_ack,
`endif
  output logic          lock_zero,
  output logic          lock_one,
  output logic          lock_rst,
  output logic          door_open,
  output logic          lockout,
  output logic          alarm,
  output logic [FW-1:0] fail_cnt,
  output logic [2:0]    ctrl_state
);

  localparam int TMAX_A = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX   = (TMAX_A > ENTRY_TIMEOUT) ? TMAX_A : ENTRY_TIMEOUT;
  localparam int TW     = $clog2(TMAX) + 1;
  localparam int DW     = $clog2(CODE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [DW-1:0] digit_cnt, digit_next;
  logic [FW-1:0] fail_next, fail_inc;
  logic          zero_next, one_next;
  logic          valid_key, lock_done;

  assign valid_key = key_zero ^ key_one;
  assign fail_inc  = (fail_cnt >= FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;

  // With acknowledge enabled the timer parks past expiry and waits for alarm_ack.
`ifdef LOCK_ALARM_ACK_EN
  assign lock_done = (timer >= TW'(LOCKOUT_CYCLES - 1)) && alarm_ack;
`else
  assign lock_done = (timer >= TW'(LOCKOUT_CYCLES - 1));
`endif

  always_comb begin
    state_next = state;
    timer_next = (timer == '1) ? timer : timer + 1'b1;
    digit_next = digit_cnt;
    fail_next  = fail_cnt;
    zero_next  = 1'b0;
    one_next   = 1'b0;
    case (state)
      S_IDLE: begin
        digit_next = '0;
        if (valid_key) begin
          state_next = S_ENTRY;
          zero_next  = key_zero;
          one_next   = key_one;
          digit_next = DW'(1);
        end
      end
      S_ENTRY: begin
        if (key_clear) begin
          state_next = S_IDLE;
        end else if (valid_key) begin
          zero_next  = key_zero;
          one_next   = key_one;
          digit_next = digit_cnt + 1'b1;
          timer_next = '0;
          if (digit_cnt == DW'(CODE_LEN - 1)) state_next = S_CHECK;
        end else if (timer >= TW'(ENTRY_TIMEOUT - 1)) begin
          state_next = S_FAIL;
        end
      end
      S_CHECK: begin
        if (lock_unlocked) begin
          state_next = S_OPEN;
          fail_next  = '0;
        end else begin
          state_next = S_FAIL;
        end
      end
      S_OPEN: begin
        if (key_clear || (timer >= TW'(OPEN_CYCLES - 1))) state_next = S_IDLE;
      end
      S_FAIL: begin
        fail_next  = fail_inc;
        state_next = (fail_inc == FW'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_done) begin
          state_next = S_IDLE;
          fail_next  = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Every state change restarts the shared timer.
    if (state_next != state) timer_next = '0;
    if (state_next == S_IDLE) digit_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      lock_zero <= 1'b0;
      lock_one  <= 1'b0;
      lock_rst  <= 1'b1;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      digit_cnt <= digit_next;
      fail_cnt  <= fail_next;
      lock_zero <= zero_next;
      lock_one  <= one_next;
      lock_rst  <= (state_next == S_IDLE) || (state_next == S_LOCKOUT);
    end
  end

  assign door_open  = (state == S_OPEN);
  assign lockout    = (state == S_LOCKOUT);
  assign alarm      = (state == S_LOCKOUT);
  assign ctrl_state = state;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Directed bench for lock_entry_ctrl: forwarded digit pulses are scoreboarded cycle by cycle,
// state/timing checks are inline immediate assertions.
module tb_lock_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_zero = 1'b0, key_one = 1'b0, key_clear = 1'b0, lock_unlocked = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       lock_zero, lock_one, lock_rst, door_open, lockout, alarm;
  logic [1:0] fail_cnt;
  logic [2:0] ctrl_state;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  int         n;

  lock_entry_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .key_zero(key_zero), .key_one(key_one), .key_clear(key_clear),
    .lock_unlocked(lock_unlocked),
`ifdef LOCK_ALARM_ACK_EN
    .alarm_ack(alarm_ack),
`endif
    .lock_zero(lock_zero), .lock_one(lock_one), .lock_rst(lock_rst),
    .door_open(door_open), .lockout(lockout), .alarm(alarm),
    .fail_cnt(fail_cnt), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; fwd says whether the DUT should forward this key.
  task automatic cyc(input logic z, input logic o, input logic c, input logic a, input logic fwd);
    @(negedge clk); #1;
    key_zero = z; key_one = o; key_clear = c; alarm_ack = a;
    exp_q.push_back(fwd ? {z, o} : 2'b00);
    @(posedge clk); #1;
    key_zero = 1'b0; key_one = 1'b0; key_clear = 1'b0; alarm_ack = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Forwarded pulses appear one cycle after the key; the queue holds that cycle's expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("fwd", 32'({lock_zero, lock_one}), 32'(exp_q.pop_front()));
  end

  initial begin
    logic [4:0] code;
    // Reset values
    idle(2);
    check("rst_state", ctrl_state, 0);
    check("rst_lock_rst", lock_rst, 1);
    check("rst_outs", {door_open, lockout, alarm, lock_zero, lock_one}, 0);
    check("rst_fail", fail_cnt, 0);
    rst_n = 1'b1;

    // Correct code 0,1,0,1,1
    lock_unlocked = 1'b1;
    code = 5'b01011;
    for (int k = 0; k < 5; k++) begin
      cyc(code[4-k] == 1'b0, code[4-k] == 1'b1, 1'b0, 1'b0, 1'b1);
      if (k < 4) begin
        check("ok_entry", ctrl_state, 1);
        check("ok_lock_rst", lock_rst, 0);
        idle(1);
      end
    end
    check("ok_check", ctrl_state, 2);
    idle(1);
    check("ok_open", ctrl_state, 3);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!door_open) break;
      n++;
      idle(1);
    end
    check("ok_open_len", n, 16);
    check("ok_idle", ctrl_state, 0);
    check("ok_fail", fail_cnt, 0);

    // Wrong code three times -> lockout
    lock_unlocked = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      for (int k = 0; k < 5; k++) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        if (k < 4) idle(1);
      end
      check("wr_check", ctrl_state, 2);
      idle(1);
      check("wr_fail_state", ctrl_state, 4);
      idle(1);
      check("wr_cnt", fail_cnt, a);
      check("wr_next", ctrl_state, (a == 3) ? 5 : 0);
    end
    check("lk_flags", {lockout, alarm, lock_rst}, 3'b111);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!lockout) break;
      n++;
      if (i == 67) check("lk_alarm_hold", alarm, 1);
      cyc((i % 3) == 0, (i % 7) == 1, (i % 5) == 0, (i == 10) || (i == 70), 1'b0);
    end
`ifdef LOCK_ALARM_ACK_EN
    check("lk_len", n, 71);
`else
    check("lk_len", n, 64);
`endif
    check("lk_exit_state", ctrl_state, 0);
    check("lk_exit_fail", fail_cnt, 0);
    check("lk_exit_flags", {lockout, alarm, lock_rst}, 3'b001);

    // Clear mid-entry, clear wins over a simultaneous key
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_state", ctrl_state, 0);
    check("clr_lock_rst", lock_rst, 1);
    check("clr_fail", fail_cnt, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_idle_noop", ctrl_state, 0);

    // Entry timeout
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(31);
    check("to_still_entry", ctrl_state, 1);
    idle(1);
    check("to_fail_state", ctrl_state, 4);
    idle(1);
    check("to_idle", ctrl_state, 0);
    check("to_fail_cnt", fail_cnt, 1);

    // Simultaneous keys ignored, then open and reset mid-OPEN
    lock_unlocked = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("both_digit", ctrl_state, (k == 3) ? 2 : 1);
      if (k < 3) idle(1);
    end
    idle(1);
    check("both_open", ctrl_state, 3);
    check("both_fail_clr", fail_cnt, 0);
    idle(3);
    check("rst_pre_door", door_open, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_door", door_open, 0);
    check("arst_lock_rst", lock_rst, 1);
    check("arst_state", ctrl_state, 0);
    #3 rst_n = 1'b1;
    idle(2);
    check("post_rst_state", ctrl_state, 0);
    check("post_rst_door", door_open, 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
